pid_core: RTL and testbench

PID_CORE -- requirements
Module: pid_core

---
 rtl/pid_core.sv | 213 +++++++++++++++++++++
 tb/tb_pid_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_core.sv
// pid_core: time-multiplexed multi-channel PID controller.
// One sample is processed at a time through ERR -> MUL -> SUM -> SAT -> OUT.
// Each channel keeps its own integrator, previous error and history flag.
// Optional build macro PID_CORE_ANTIWINDUP_EN enables conditional integration
// (integrator frozen while the output is clipped in the direction of the error).
module pid_core #(
  parameter int NCH    = 2,
  parameter int DATA_W = 13,
  parameter int GAIN_W = 13,
  parameter int FRAC_W = 6,
  parameter int INT_W  = 26,
  parameter int OUT_W  = 16,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic [DATA_W-1:0]       in_meas,
  input  logic [DATA_W-1:0]       target,
  input  logic [GAIN_W-1:0]       k_p,
  input  logic [GAIN_W-1:0]       k_i,
  input  logic [GAIN_W-1:0]       k_d,
  input  logic                    clr_valid,
  input  logic [CH_W-1:0]         clr_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [OUT_W-1:0] out_u,
  output logic                    out_sat
);

  localparam int E_W  = DATA_W + 1;
  localparam int D_W  = DATA_W + 2;
  localparam int GS_W = GAIN_W + 1;
  localparam int PP_W = E_W + GS_W;
  localparam int PI_W = INT_W + GS_W;
  localparam int PD_W = D_W + GS_W;
  localparam int PM_W = (PI_W > PD_W) ? PI_W : PD_W;
  localparam int S_W  = PM_W + 2;

  localparam logic [CH_W:0]             NCH_L = (CH_W + 1)'(NCH);
  localparam logic signed [INT_W:0]     IMAX  = {2'b00, {(INT_W - 1){1'b1}}};
  localparam logic signed [INT_W:0]     IMIN  = -IMAX;
  localparam logic signed [S_W-1:0]     OMAX  = S_W'({1'b0, {(OUT_W - 1){1'b1}}});
  localparam logic signed [S_W-1:0]     OMIN  = ~OMAX;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_SAT, S_OUT} state_t;
  state_t r_state, w_state_nx;

  // transaction operands
  logic [CH_W-1:0]          r_ch;
  logic [DATA_W-1:0]        r_meas, r_target;
  logic [GAIN_W-1:0]        r_kp, r_ki, r_kd;
  logic signed [E_W-1:0]    r_e;
  logic signed [INT_W-1:0]  r_integ_new;
  logic signed [D_W-1:0]    r_d;
  logic signed [PP_W-1:0]   r_pp;
  logic signed [PI_W-1:0]   r_pi;
  logic signed [PD_W-1:0]   r_pd;
  logic signed [S_W-1:0]    r_s;
  logic                     r_clr_hit;
  logic [CH_W-1:0]          r_out_ch;
  logic signed [OUT_W-1:0]  r_out_u;
  logic                     r_out_sat;

  // per-channel state
  logic signed [INT_W-1:0]  r_integ [NCH];
  logic signed [E_W-1:0]    r_eprev [NCH];
  logic [NCH-1:0]           r_hist;

  logic                     w_accept, w_in_ok, w_clr_ok, w_clr_cur;
  logic signed [E_W-1:0]    w_e;
  logic signed [INT_W:0]    w_isum;
  logic signed [INT_W-1:0]  w_integ_new;
  logic signed [D_W-1:0]    w_d;
  logic signed [PP_W-1:0]   w_pp;
  logic signed [PI_W-1:0]   w_pi;
  logic signed [PD_W-1:0]   w_pd;
  logic signed [S_W-1:0]    w_sum;
  logic                     w_hi, w_lo, w_skip_i, w_wb;
  logic signed [OUT_W-1:0]  w_u;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_OUT);
  assign out_ch    = r_out_ch;
  assign out_u     = r_out_u;
  assign out_sat   = r_out_sat;

  // handshake and clear decode
  always_comb begin
    w_accept  = in_valid && in_ready;
    w_in_ok   = {1'b0, in_ch} < NCH_L;
    w_clr_ok  = clr_valid && ({1'b0, clr_ch} < NCH_L);
    w_clr_cur = w_clr_ok && (clr_ch == r_ch);
  end

  // error, saturating integrator and derivative for the latched sample
  always_comb begin
    w_e    = $signed({1'b0, r_target}) - $signed({1'b0, r_meas});
    w_isum = (INT_W + 1)'(r_integ[r_ch]) + (INT_W + 1)'(w_e);
    if (w_isum > IMAX)      w_integ_new = IMAX[INT_W-1:0];
    else if (w_isum < IMIN) w_integ_new = IMIN[INT_W-1:0];
    else                    w_integ_new = w_isum[INT_W-1:0];
    if (r_hist[r_ch]) w_d = D_W'(w_e) - D_W'(r_eprev[r_ch]);
    else              w_d = '0;
  end

  // full-width products, sum and output clipping
  always_comb begin
    w_pp  = PP_W'(r_e)         * PP_W'($signed({1'b0, r_kp}));
    w_pi  = PI_W'(r_integ_new) * PI_W'($signed({1'b0, r_ki}));
    w_pd  = PD_W'(r_d)         * PD_W'($signed({1'b0, r_kd}));
    w_sum = S_W'(r_pp) + S_W'(r_pi) + S_W'(r_pd);
    w_hi  = r_s > OMAX;
    w_lo  = r_s < OMIN;
    if (w_hi)      w_u = OMAX[OUT_W-1:0];
    else if (w_lo) w_u = OMIN[OUT_W-1:0];
    else           w_u = r_s[OUT_W-1:0];
  end

`ifdef PID_CORE_ANTIWINDUP_EN
  assign w_skip_i = (w_hi && !r_e[E_W-1] && (r_e != '0)) || (w_lo && r_e[E_W-1]);
`else
  assign w_skip_i = 1'b0;
`endif

  // a clear of the in-flight channel at any point of the transaction cancels its writeback
  assign w_wb = (r_state == S_SAT) && !r_clr_hit && !w_clr_cur;

  // next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_in_ok) w_state_nx = S_ERR;
      S_ERR:   w_state_nx = S_MUL;
      S_MUL:   w_state_nx = S_SUM;
      S_SUM:   w_state_nx = S_SAT;
      S_SAT:   w_state_nx = S_OUT;
      S_OUT:   if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // pipeline operand registers (only consumed in their own stage, no reset needed)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept && w_in_ok) begin
      r_ch     <= in_ch;
      r_meas   <= in_meas;
      r_target <= target;
      r_kp     <= k_p;
      r_ki     <= k_i;
      r_kd     <= k_d;
    end
    if (r_state == S_ERR) begin
      r_e         <= w_e;
      r_integ_new <= w_integ_new;
      r_d         <= w_d;
    end
    if (r_state == S_MUL) begin
      r_pp <= w_pp;
      r_pi <= w_pi;
      r_pd <= w_pd;
    end
    if (r_state == S_SUM) r_s <= w_sum >>> FRAC_W;
  end

  // output registers and in-flight clear tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_ch  <= '0;
      r_out_u   <= '0;
      r_out_sat <= 1'b0;
      r_clr_hit <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_clr_hit <= 1'b0;
      else if ((r_state == S_ERR || r_state == S_MUL || r_state == S_SUM) && w_clr_cur)
        r_clr_hit <= 1'b1;
      if (r_state == S_SAT) begin
        r_out_ch  <= r_ch;
        r_out_u   <= w_u;
        r_out_sat <= w_hi || w_lo;
      end
    end
  end

  // per-channel writeback; a clear issued in the same cycle takes precedence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_integ <= '{default: '0};
      r_eprev <= '{default: '0};
      r_hist  <= '0;
    end else begin
      if (w_wb) begin
        if (!w_skip_i) r_integ[r_ch] <= r_integ_new;
        r_eprev[r_ch] <= r_e;
        r_hist[r_ch]  <= 1'b1;
      end
      if (w_clr_ok) begin
        r_integ[clr_ch] <= '0;
        r_hist[clr_ch]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pid_core.sv
// Directed-vector bench for pid_core, built with NCH=3 so an out-of-range
// channel index is representable. Expected values are hand-computed with
// FRAC_W=6, so a gain of 64 is unity.
module tb_pid_core;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_ch = '0;
  logic [12:0]        in_meas = '0;
  logic [12:0]        target = '0;
  logic [12:0]        k_p = '0, k_i = '0, k_d = '0;
  logic               clr_valid = 1'b0;
  logic [1:0]         clr_ch = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         out_ch;
  logic signed [15:0] out_u;
  logic               out_sat;

  int n_cmp = 0;
  int n_err = 0;

  pid_core #(.NCH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_meas(in_meas), .target(target),
    .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .clr_valid(clr_valid), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_u(out_u), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic accept_sample(input int ch, input int tgt, input int meas,
                               input int kp, input int ki, input int kd);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'(ch); target = 13'(tgt); in_meas = 13'(meas);
    k_p = 13'(kp); k_i = 13'(ki); k_d = 13'(kd);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_wait in_ready got %0b exp 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_output(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input int ch, input int tgt, input int meas,
                     input int kp, input int ki, input int kd,
                     output int u, output logic sat, output int och, output int lat);
    accept_sample(ch, tgt, meas, kp, ki, kd);
    wait_output(lat);
    u = int'(out_u); sat = out_sat; och = int'(out_ch);
    ack_output();
  endtask

  task automatic clear_ch(input int ch);
    @(negedge clk); clr_valid = 1'b1; clr_ch = 2'(ch);
    @(posedge clk); #1; clr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    n_cmp++; if (out_u !== 16'sd0)   begin n_err++; $display("FAIL rst_out_u got %0d exp 0", out_u); end
    n_cmp++; if (out_ch !== 2'd0)    begin n_err++; $display("FAIL rst_out_ch got %0d exp 0", out_ch); end
    n_cmp++; if (out_sat !== 1'b0)   begin n_err++; $display("FAIL rst_out_sat got %0b exp 0", out_sat); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL idle_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_prop();
    int u, och, lat; logic sat;
    run(0, 1024, 1000, 64, 0, 0, u, sat, och, lat);
    n_cmp++; if (lat !== 4)   begin n_err++; $display("FAIL prop_latency got %0d exp 4", lat); end
    n_cmp++; if (u !== 24)    begin n_err++; $display("FAIL prop_u got %0d exp 24", u); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL prop_sat got %0b exp 0", sat); end
    n_cmp++; if (och !== 0)   begin n_err++; $display("FAIL prop_ch got %0d exp 0", och); end
    // -1 >>> 6 must stay -1
    run(0, 0, 1, 1, 0, 0, u, sat, och, lat);
    n_cmp++; if (u !== -1 || sat !== 1'b0) begin
      n_err++; $display("FAIL prop_arith_shift got %0d/%0b exp -1/0", u, sat);
    end
  endtask

  task automatic test_integ();
    int u, och, lat; logic sat;
    for (int k = 1; k <= 3; k++) begin
      run(1, 110, 100, 0, 64, 0, u, sat, och, lat);
      n_cmp++; if (u !== 10 * k || och !== 1) begin
        n_err++; $display("FAIL integ_step%0d got %0d ch %0d exp %0d ch 1", k, u, och, 10 * k);
      end
    end
    clear_ch(1);
    run(1, 110, 100, 0, 64, 0, u, sat, och, lat);
    n_cmp++; if (u !== 10) begin n_err++; $display("FAIL integ_after_clr got %0d exp 10", u); end
    // clear of the in-flight channel during MUL: output still 20, writeback lost
    accept_sample(1, 110, 100, 0, 64, 0);
    @(posedge clk); #1;
    clr_valid = 1'b1; clr_ch = 2'd1;
    @(posedge clk); #1;
    clr_valid = 1'b0;
    wait_output(lat);
    n_cmp++; if (lat !== 2 || out_u !== 16'sd20) begin
      n_err++; $display("FAIL integ_midclr_out got %0d lat %0d exp 20 lat 2", out_u, lat);
    end
    ack_output();
    run(1, 110, 100, 0, 64, 0, u, sat, och, lat);
    n_cmp++; if (u !== 10) begin n_err++; $display("FAIL integ_midclr_wb got %0d exp 10", u); end
  endtask

  task automatic test_deriv();
    int u, och, lat; logic sat;
    int tg[3] = '{500, 550, 500};
    int ex[3] = '{0, 50, -50};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run(0, tg[k], 500, 0, 0, 64, u, sat, och, lat);
      n_cmp++; if (u !== ex[k]) begin
        n_err++; $display("FAIL deriv_step%0d got %0d exp %0d", k, u, ex[k]);
      end
    end
    do_reset();
    run(0, 550, 500, 0, 0, 64, u, sat, och, lat);
    n_cmp++; if (u !== 0) begin n_err++; $display("FAIL deriv_first_after_rst got %0d exp 0", u); end
  endtask

  task automatic test_sat();
    int u, och, lat, exp_i; logic sat;
`ifdef PID_CORE_ANTIWINDUP_EN
    exp_i = 0;
`else
    exp_i = 4095;
`endif
    do_reset();
    run(0, 4095, 0, 8191, 0, 0, u, sat, och, lat);
    n_cmp++; if (u !== 32767 || sat !== 1'b1) begin
      n_err++; $display("FAIL sat_pos got %0d/%0b exp 32767/1", u, sat);
    end
    // integrator probe: e=0, unity k_i, so out_u equals the stored integrator
    run(0, 0, 0, 0, 64, 0, u, sat, och, lat);
    n_cmp++; if (u !== exp_i || sat !== 1'b0) begin
      n_err++; $display("FAIL sat_integ_probe got %0d/%0b exp %0d/0", u, sat, exp_i);
    end
    run(1, 0, 4095, 8191, 0, 0, u, sat, och, lat);
    n_cmp++; if (u !== -32768 || sat !== 1'b1) begin
      n_err++; $display("FAIL sat_neg got %0d/%0b exp -32768/1", u, sat);
    end
  endtask

  task automatic test_stall();
    int lat; logic ok;
    accept_sample(2, 107, 100, 64, 0, 0);
    wait_output(lat);
    n_cmp++; if (lat !== 4 || out_u !== 16'sd7) begin
      n_err++; $display("FAIL stall_first got %0d lat %0d exp 7 lat 4", out_u, lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      ok = (out_valid === 1'b1) && (out_u === 16'sd7) && (out_ch === 2'd2) &&
           (out_sat === 1'b0) && (in_ready === 1'b0);
      n_cmp++; if (!ok) begin
        n_err++; $display("FAIL stall_hold%0d got v=%0b u=%0d ch=%0d rdy=%0b exp v=1 u=7 ch=2 rdy=0",
                          c, out_valid, out_u, out_ch, in_ready);
      end
    end
    ack_output();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_release got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midflight();
    int u, och, lat; logic sat, seen;
    do_reset();
    run(0, 200, 100, 0, 64, 64, u, sat, och, lat);
    n_cmp++; if (u !== 100) begin n_err++; $display("FAIL rstmid_pre got %0d exp 100", u); end
    accept_sample(0, 200, 100, 0, 64, 64);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_valid got %0b exp 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_idle got %0b exp 1", in_ready); end
    run(0, 105, 100, 0, 64, 64, u, sat, och, lat);
    n_cmp++; if (u !== 5) begin n_err++; $display("FAIL rstmid_state_zeroed got %0d exp 5", u); end
  endtask

  task automatic test_interleave();
    int u, och, lat; logic seen, sat;
    int chs[6] = '{0, 1, 0, 1, 0, 1};
    int tgs[6] = '{110, 80, 130, 95, 110, 95};
    int exs[6] = '{10, -20, 60, -10, 30, -30};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        // out-of-range channel is consumed and ignored
        accept_sample(3, 4000, 0, 8191, 8191, 8191);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_idle got %0b exp 1", in_ready); end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL drop_no_output got %0b exp 0", seen); end
      end
      run(chs[k], tgs[k], 100, 0, 64, 64, u, sat, och, lat);
      n_cmp++; if (u !== exs[k] || och !== chs[k]) begin
        n_err++; $display("FAIL interleave%0d got %0d ch %0d exp %0d ch %0d", k, u, och, exs[k], chs[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prop();
    test_integ();
    test_deriv();
    test_sat();
    test_stall();
    test_reset_midflight();
    test_interleave();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
